// File: rtl/regfile_sb.sv
// regfile_sb: register file with a write-pending scoreboard and a
// background clear sweep.
// - Register 0 always reads 0.
// - Reads are combinational.
// - Writes, trigger and scoreboard updates are accepted only in IDLE.
// - A clear request zeroes registers 1..DEPTH-1, one per cycle, while
//   clr_busy is high.
// Optional feature: define REGFILE_BYPASS_EN to forward the write data
// to RD1/RD2 in the same cycle the write is presented.
module regfile_sb #(
   parameter int ADDRESS_WIDTH = 5,
   parameter int DATA_WIDTH    = 32,
   parameter int TRIG_REG      = 5,
   parameter int OUT_REG       = 10
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [ADDRESS_WIDTH-1:0] A1,
   input  logic [ADDRESS_WIDTH-1:0] A2,
   output logic [DATA_WIDTH-1:0]    RD1,
   output logic [DATA_WIDTH-1:0]    RD2,
   input  logic [ADDRESS_WIDTH-1:0] A3,
   input  logic [DATA_WIDTH-1:0]    WD3,
   input  logic                     WE3,
   input  logic                     trigger,
   input  logic                     issue_valid,
   input  logic [ADDRESS_WIDTH-1:0] issue_rd,
   output logic                     busy1,
   output logic                     busy2,
   input  logic                     clr_req,
   output logic                     clr_busy,
   output logic [DATA_WIDTH-1:0]    a0,
   output logic [DATA_WIDTH-1:0]    ra
);

   localparam int DEPTH = 2**ADDRESS_WIDTH;
   localparam logic [ADDRESS_WIDTH-1:0] LAST_IDX = ADDRESS_WIDTH'(DEPTH-1);
   localparam logic [ADDRESS_WIDTH-1:0] TRIG_IDX = ADDRESS_WIDTH'(TRIG_REG);
   localparam logic [ADDRESS_WIDTH-1:0] OUT_IDX  = ADDRESS_WIDTH'(OUT_REG);
   localparam logic [ADDRESS_WIDTH-1:0] RA_IDX   = ADDRESS_WIDTH'(1);

   typedef enum logic {
      IDLE,
      CLEAR
   } state_t;

   state_t                   state;
   state_t                   next_state;
   logic [ADDRESS_WIDTH-1:0] sweep_cnt;
   logic [DATA_WIDTH-1:0]    regs [DEPTH];
   logic [DEPTH-1:0]         pend;
   logic                     in_idle;
   logic                     sweep_start;
   logic                     sweep_done;
   logic                     wr_hit;
   logic                     trig_hit;

   // State register; reset aborts any sweep in progress.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next state and sweep control; clr_req is only looked at in IDLE.
   always_comb begin
      next_state  = state;
      in_idle     = 1'b0;
      sweep_start = 1'b0;
      sweep_done  = 1'b0;
      clr_busy    = 1'b0;
      case (state)
         IDLE: begin
            in_idle = 1'b1;
            if (clr_req) begin
               next_state  = CLEAR;
               sweep_start = 1'b1;
            end
         end
         CLEAR: begin
            clr_busy = 1'b1;
            if (sweep_cnt == LAST_IDX) begin
               sweep_done = 1'b1;
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // Sweep counter starts at 1 and stops on the last index instead of wrapping to 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sweep_cnt <= '0;
      end else if (sweep_start) begin
         sweep_cnt <= ADDRESS_WIDTH'(1);
      end else if (clr_busy && !sweep_done) begin
         sweep_cnt <= sweep_cnt + ADDRESS_WIDTH'(1);
      end
   end

   // Index 0 is never a legal write target; trigger takes priority over WE3.
   always_comb begin
      trig_hit = in_idle && trigger && (TRIG_IDX != '0);
      wr_hit   = in_idle && WE3 && (A3 != '0) && !(trig_hit && (A3 == TRIG_IDX));
   end

   // Register array: the sweep zeroes one entry per cycle, otherwise normal writes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs[ADDRESS_WIDTH'(i)] <= '0;
         end
      end else if (clr_busy) begin
         if (sweep_cnt != '0) begin
            regs[sweep_cnt] <= '0;
         end
      end else begin
         if (wr_hit) begin
            regs[A3] <= WD3;
         end
         if (trig_hit) begin
            regs[TRIG_IDX] <= DATA_WIDTH'(1);
         end
      end
   end

   // Scoreboard: a write retires a pending flag, an issue sets one; set is last so it wins.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend <= '0;
      end else if (sweep_start) begin
         pend <= '0;
      end else if (in_idle) begin
         if (WE3 && (A3 != '0)) begin
            pend[A3] <= 1'b0;
         end
         if (issue_valid && (issue_rd != '0)) begin
            pend[issue_rd] <= 1'b1;
         end
      end
   end

   // Combinational read ports; pend[0] is never set, so busy is 0 for index 0.
   always_comb begin
      busy1 = pend[A1];
      busy2 = pend[A2];
      a0    = regs[OUT_IDX];
      ra    = regs[RA_IDX];
`ifdef REGFILE_BYPASS_EN
      RD1 = (in_idle && WE3 && (A3 != '0) && (A3 == A1)) ? WD3 : regs[A1];
      RD2 = (in_idle && WE3 && (A3 != '0) && (A3 == A2)) ? WD3 : regs[A2];
`else
      RD1 = regs[A1];
      RD2 = regs[A2];
`endif
   end

endmodule
